// File: rtl/seven_seg_scan_driver_pkg.sv
// Shared constants and the BCD-to-segment decode for the scanned display driver.
// Segment bit 0 = a ... bit 6 = g, active-high patterns.
package seven_seg_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F,
        SEG_BLANK, SEG_BLANK, SEG_BLANK,
        SEG_BLANK, SEG_BLANK, SEG_BLANK
    };

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        return SEG_TABLE[bcd];
    endfunction

endpackage

// File: rtl/seven_seg_scan_driver_scan_prescaler.sv
// Enabled wrap-around counter 0..DIV-1; tc pulses combinationally on the
// enabled cycle that wraps it back to 0.
module scan_prescaler #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tc
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tc    = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = '0;
                tc    = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed BCD-to-7-segment driver with shadow capture and blink.
// Define LEADING_ZERO_BLANK_EN to suppress leading zeros above digit 0.
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS     = 3,
    parameter int SCAN_DIV       = 1000,
    parameter int BLINK_FRAMES   = 64,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [4*NUM_DIGITS-1:0]   digits_in,
    input  logic                      load,
    input  logic                      blink,
    output logic [6:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     digit_sel
);

    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);
    localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? ~SEG_BLANK : SEG_BLANK;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    phase_q, phase_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   sel_q, sel_d;

    logic       scan_tc;
    logic       frame_en;
    logic       frame_tc;
    logic [3:0] nib;
    logic       lead_zero;

    scan_prescaler #(.DIV(SCAN_DIV)) u_scan_div (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .tc    (scan_tc)
    );

    // A frame completes when the digit index wraps back to 0.
    assign frame_en = scan_tc && (idx_q == LAST_IDX);

    scan_prescaler #(.DIV(BLINK_FRAMES)) u_frame_div (
        .clk   (clk),
        .reset (reset),
        .en    (frame_en),
        .tc    (frame_tc)
    );

    always_comb begin
        shadow_d = load ? digits_in : shadow_q;
        idx_d    = idx_q;
        if (scan_tc) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IW'(1);
        end
        phase_d = phase_q ^ frame_tc;
    end

    // Outputs follow the current idx/shadow, so they lag them by one clock.
    always_comb begin
        nib       = '0;
        sel_d     = '0;
        lead_zero = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx_q == IW'(k)) begin
                nib      = shadow_q[4*k +: 4];
                sel_d[k] = 1'b1;
`ifdef LEADING_ZERO_BLANK_EN
                lead_zero = (k != 0) && ((shadow_q >> (4*k)) == '0);
`else
                lead_zero = 1'b0;
`endif
            end
        end
        seg_d = lead_zero ? SEG_BLANK : seg_decode(nib);
        if (blink && phase_q) begin
            seg_d = SEG_BLANK;
            sel_d = '0;
        end
        if (SEG_ACTIVE_LOW != 0) begin
            seg_d = ~seg_d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            idx_q    <= '0;
            phase_q  <= 1'b0;
            seg_q    <= SEG_OFF;
            sel_q    <= '0;
        end else begin
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            phase_q  <= phase_d;
            seg_q    <= seg_d;
            sel_q    <= sel_d;
        end
    end

    assign seg_out   = seg_q;
    assign digit_sel = sel_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Scoreboarded random/directed bench for seven_seg_scan_driver; expected
// outputs come from an arithmetic model of scan position, frame and blink phase.
module tb_seven_seg_scan_driver;

    localparam int N   = 3;
    localparam int SD  = 4;
    localparam int BF  = 2;
    localparam int SAL = 0;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [4*N-1:0] digits_in = '0;
    logic          load = 1'b0;
    logic          blink = 1'b0;
    logic [6:0]    seg_out;
    logic [N-1:0]  digit_sel;

    seven_seg_scan_driver #(
        .NUM_DIGITS     (N),
        .SCAN_DIV       (SD),
        .BLINK_FRAMES   (BF),
        .SEG_ACTIVE_LOW (SAL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .digits_in (digits_in),
        .load      (load),
        .blink     (blink),
        .seg_out   (seg_out),
        .digit_sel (digit_sel)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]   seg;
        logic [N-1:0] sel;
        int           tag;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    // Model state: clock edges since reset released, and captured value.
    int             m_t = 0;
    logic [4*N-1:0] m_shadow = '0;
    logic [6:0]     dec_tbl [10];

    function automatic exp_t model_out(input logic rst, input logic bl);
        exp_t       e;
        int         idx;
        int         frame;
        logic [3:0] d;
        logic [6:0] pat;
        e.tag = cyc;
        if (rst) begin
            e.seg = (SAL != 0) ? 7'h7F : 7'h00;
            e.sel = '0;
            return e;
        end
        idx   = (m_t / SD) % N;
        frame = m_t / (SD * N);
        e.sel = N'(1 << idx);
        d     = m_shadow[4*idx +: 4];
        pat   = (d <= 4'd9) ? dec_tbl[d] : 7'h00;
`ifdef LEADING_ZERO_BLANK_EN
        if (idx > 0 && (m_shadow >> (4*idx)) == 0) pat = 7'h00;
`endif
        if (bl && ((frame / BF) % 2 == 1)) begin
            pat   = 7'h00;
            e.sel = '0;
        end
        e.seg = (SAL != 0) ? ~pat : pat;
        return e;
    endfunction

    task automatic step(input logic r, input logic ld, input logic [4*N-1:0] din, input logic bl);
        reset     = r;
        load      = ld;
        digits_in = din;
        blink     = bl;
        exp_q.push_back(model_out(r, bl));
        if (r) begin
            m_t      = 0;
            m_shadow = '0;
        end else begin
            m_t++;
            if (ld) m_shadow = din;
        end
        cyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [4*N-1:0] din, input logic bl);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, din, bl);
    endtask

    // Monitor: the DUT presents a new output every clock.
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (seg_out === e.seg) passed++;
                else $display("FAIL seg_out cyc=%0d got=%h exp=%h", e.tag, seg_out, e.seg);
                checks++;
                if (digit_sel === e.sel) passed++;
                else $display("FAIL digit_sel cyc=%0d got=%b exp=%b", e.tag, digit_sel, e.sel);
            end
        end
    end

    initial begin
        logic [4*N-1:0] din;
        logic           bl;
        dec_tbl[0] = 7'h3F; dec_tbl[1] = 7'h06; dec_tbl[2] = 7'h5B;
        dec_tbl[3] = 7'h4F; dec_tbl[4] = 7'h66; dec_tbl[5] = 7'h6D;
        dec_tbl[6] = 7'h7D; dec_tbl[7] = 7'h07; dec_tbl[8] = 7'h7F;
        dec_tbl[9] = 7'h6F;

        // Reset then free-run with empty shadow.
        step(1'b1, 1'b0, '0, 1'b0);
        step(1'b1, 1'b0, '0, 1'b0);
        idle(14, '0, 1'b0);

        // Load 4:20, then change input without load.
        step(1'b0, 1'b1, 12'h420, 1'b0);
        idle(13, 12'h420, 1'b0);
        idle(13, 12'h777, 1'b0);

        // Invalid BCD codes blank.
        step(1'b0, 1'b1, 12'h9AF, 1'b0);
        idle(13, 12'h9AF, 1'b0);

        // Blink across several frames, then release.
        step(1'b0, 1'b1, 12'h123, 1'b0);
        idle(40, 12'h123, 1'b1);
        idle(14, 12'h123, 1'b0);

        // Reset mid-frame while digit 2 is being driven.
        for (int i = 0; i < 20 && ((m_t / SD) % N) != 2; i++) idle(1, 12'h123, 1'b0);
        idle(1, 12'h123, 1'b0);
        step(1'b1, 1'b0, 12'h123, 1'b0);
        idle(14, 12'h123, 1'b0);

        // Leading-zero values.
        step(1'b0, 1'b1, 12'h005, 1'b0);
        idle(13, 12'h005, 1'b0);
        step(1'b0, 1'b1, 12'h000, 1'b0);
        idle(13, 12'h000, 1'b0);
        step(1'b0, 1'b1, 12'h050, 1'b0);
        idle(13, 12'h050, 1'b0);

        // Randomized traffic.
        bl = 1'b0;
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) begin
                din[4*k +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                              : ($urandom_range(0, 2) == 0) ? 4'd0
                              : 4'($urandom_range(0, 9));
            end
            if ($urandom_range(0, 31) == 0) bl = ~bl;
            step(($urandom_range(0, 149) == 0), ($urandom_range(0, 7) == 0), din, bl);
        end

        @(posedge clk);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
